// File: rtl/ram_port_arb.sv
// Round-robin owner of RAM port A for NREQ requesters, with burst cap and exclusive upgrade lock.
// Grant and RAM port are combinational with req; read data returns one cycle later; losers hold req.
module ram_port_arb #(
  parameter int XLEN      = 32,
  parameter int ADDR_LEN  = 14,
  parameter int NREQ      = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rstb_in,
  input  logic                         lock,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*(XLEN/8)-1:0]     req_we,
  input  logic [NREQ*ADDR_LEN-1:0]     req_addr,
  input  logic [NREQ*XLEN-1:0]         req_wdata,
  output logic [NREQ-1:0]              gnt,
  output logic [NREQ-1:0]              rvalid,
  output logic [XLEN-1:0]              rdata,
  output logic                         ram_en,
  output logic [XLEN/8-1:0]            ram_we,
  output logic [ADDR_LEN-1:0]          ram_addr,
  output logic [XLEN-1:0]              ram_wdata,
  input  logic [XLEN-1:0]              ram_rdata
);
  localparam int BW = XLEN / 8;
  localparam int IW = $clog2(NREQ);
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

  logic            owner_vld_q, owner_vld_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

  logic            rr_hit;
  logic [IW-1:0]   rr_idx;
  int              rr_pos;
  logic [NREQ-1:0] owner_oh;
  logic            owner_keep;
  logic            gnt_any;
  logic [IW-1:0]   gnt_idx;
  logic [BW-1:0]   sel_we;

  always_ff @(posedge clk or negedge rstb_in) begin
    if (!rstb_in) begin
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
      cnt_q       <= '0;
      rr_q        <= '0;
      rvalid_q    <= '0;
    end else begin
      owner_vld_q <= owner_vld_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // First requester at or after rr_q, wrapping from NREQ-1 back to 0.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    rr_pos = 0;
    for (int i = 0; i < NREQ; i++) begin
      rr_pos = int'(rr_q) + i;
      if (rr_pos >= NREQ) rr_pos = rr_pos - NREQ;
      if (!rr_hit && req[IW'(rr_pos)]) begin
        rr_hit = 1'b1;
        rr_idx = IW'(rr_pos);
      end
    end
  end

  always_comb begin
    owner_oh   = NREQ'(1) << owner_q;
    owner_keep = owner_vld_q && req[owner_q] &&
                 ((cnt_q < CNT_LAST) || ((req & ~owner_oh) == '0));
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!rstb_in) begin
      gnt_any = 1'b0;
    end else if (lock) begin
      gnt_any = req[0];
    end else if (owner_keep) begin
      gnt_any = 1'b1;
      gnt_idx = owner_q;
    end else begin
      gnt_any = rr_hit;
      gnt_idx = rr_idx;
    end
  end

  always_comb begin
    owner_vld_d = 1'b0;
    owner_d     = owner_q;
    cnt_d       = '0;
    rr_d        = rr_q;
    if (gnt_any) begin
      owner_vld_d = 1'b1;
      owner_d     = gnt_idx;
      if (owner_vld_q && (owner_q == gnt_idx))
        cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + 1'b1;
      rr_d = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
    end
    rvalid_d = gnt & {NREQ{~|sel_we}};
  end

  // Idle port still presents requester 0's address/data so nothing floats.
  always_comb begin
    sel_we    = req_we[BW-1:0];
    ram_addr  = req_addr[ADDR_LEN-1:0];
    ram_wdata = req_wdata[XLEN-1:0];
    for (int i = 1; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_we    = req_we[i*BW +: BW];
        ram_addr  = req_addr[i*ADDR_LEN +: ADDR_LEN];
        ram_wdata = req_wdata[i*XLEN +: XLEN];
      end
    end
    gnt    = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
    ram_en = gnt_any;
    ram_we = gnt_any ? sel_we : '0;
    rvalid = rvalid_q;
    rdata  = ram_rdata;
  end

endmodule
